lanes_rx_descrambler_sync: RTL

- Receive-path stage directly downstream of the two-lane deserializer.
- Consumes the 132-bit parallel words per lane from the deserializer, together with its enable_dec and descr_rst outputs.
- Per lane: strips and checks the sync header, descrambles the payload with the USB4 23-bit LFSR, and runs a block-lock state machine.
- Delivers aligned payload, header and a valid strobe to the decoder.

---
 rtl/lanes_rx_pkg.sv | 39 +++
 rtl/lanes_rx_descrambler_sync_lane.sv | 151 +++++++++++++++
 rtl/lanes_rx_descrambler_sync.sv | 97 +++++++++
 3 files changed

// File: rtl/lanes_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lanes_rx_pkg : shared types, speed codes, header values and LFSR helpers   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package lanes_rx_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam logic [1:0]  c_GEN4 = 2'b00;
  localparam logic [1:0]  c_GEN3 = 2'b01;
  localparam logic [1:0]  c_GEN2 = 2'b10;

  localparam logic [1:0]  c_GEN2_HDR_A = 2'b01;
  localparam logic [1:0]  c_GEN2_HDR_B = 2'b10;
  localparam logic [3:0]  c_GEN3_HDR_A = 4'b0101;
  localparam logic [3:0]  c_GEN3_HDR_B = 4'b1010;

  // Feedback taps s[22], s[20], s[15], s[7], s[4], s[1]
  localparam logic [22:0] c_LFSR_TAPS = 23'h508092;

  function automatic logic [7:0] payload_width(input logic [1:0] gen);
    case (gen)
      c_GEN3:  return 8'd128;
      c_GEN2:  return 8'd64;
      default: return 8'd8;
    endcase
  endfunction

  function automatic logic [22:0] lfsr_next(input logic [22:0] s);
    return {s[21:0], ^(s & c_LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lanes_rx_descrambler_sync_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lane_descrambler : per-lane header check, additive descrambler, lock FSM   |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module lane_descrambler
  import lanes_rx_pkg::*;
#(
  parameter logic [22:0] SEED       = 23'h1DBFBC,
  parameter int          LOCK_CNT   = 8,
  parameter int          UNLOCK_CNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         capture,
  input  logic [1:0]   gen_speed,
  input  logic [131:0] rx_in,
  output logic [127:0] data_out,
  output logic [3:0]   hdr_out,
  output logic         locked,
  output logic         sync_err
);

  localparam logic [7:0] c_LOCK_CNT   = 8'(LOCK_CNT);
  localparam logic [7:0] c_UNLOCK_CNT = 8'(UNLOCK_CNT);

  logic [1:0]   w_gen;
  logic [7:0]   w_nbits;
  logic [127:0] w_payload;
  logic [127:0] w_descr;
  logic [3:0]   w_hdr;
  logic         w_hdr_ok;
  logic [22:0]  w_lfsr_adv;

  lock_state_t  r_state;
  logic [7:0]   r_cnt;
  logic [7:0]   r_bad;
  logic [22:0]  r_lfsr;
  logic [127:0] r_data;
  logic [3:0]   r_hdr;
  logic         r_sync_err;

  assign w_gen   = (gen_speed == 2'b11) ? c_GEN4 : gen_speed;
  assign w_nbits = payload_width(w_gen);

  always_comb begin
    w_payload = '0;
    w_hdr     = '0;
    w_hdr_ok  = 1'b1;
    case (w_gen)
      c_GEN2: begin
        w_hdr           = {2'b00, rx_in[1:0]};
        w_payload[63:0] = rx_in[65:2];
        w_hdr_ok        = (rx_in[1:0] == c_GEN2_HDR_A) || (rx_in[1:0] == c_GEN2_HDR_B);
      end
      c_GEN3: begin
        w_hdr     = rx_in[3:0];
        w_payload = rx_in[131:4];
        w_hdr_ok  = (rx_in[3:0] == c_GEN3_HDR_A) || (rx_in[3:0] == c_GEN3_HDR_B);
      end
      default: w_payload[7:0] = rx_in[7:0];
    endcase
  end

  // Serial LFSR unrolled over the active payload width, oldest bit first
  always_comb begin
    w_lfsr_adv = r_lfsr;
    w_descr    = w_payload;
    for (int i = 0; i < 128; i++) begin
      if (8'(i) < w_nbits) begin
        w_descr[i] = w_payload[i] ^ w_lfsr_adv[22];
        w_lfsr_adv = lfsr_next(w_lfsr_adv);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= UNLOCKED;
      r_cnt      <= '0;
      r_bad      <= '0;
      r_lfsr     <= SEED;
      r_data     <= '0;
      r_hdr      <= '0;
      r_sync_err <= 1'b0;
    end else if (!enable) begin
      r_state    <= UNLOCKED;
      r_cnt      <= '0;
      r_bad      <= '0;
      r_lfsr     <= SEED;
      r_data     <= '0;
      r_hdr      <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      if (capture) begin
        r_data     <= w_descr;
        r_hdr      <= w_hdr;
        r_lfsr     <= w_lfsr_adv;
        r_sync_err <= !w_hdr_ok;
        case (r_state)
          UNLOCKED: begin
            if (w_hdr_ok) begin
              if ((w_gen == c_GEN4) || (c_LOCK_CNT <= 8'd1)) begin
                r_state <= LOCKED;
                r_bad   <= '0;
              end else begin
                r_state <= CHECK;
                r_cnt   <= 8'd1;
              end
            end
          end
          CHECK: begin
            if (w_hdr_ok) begin
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt + 8'd1 == c_LOCK_CNT) begin
                r_state <= LOCKED;
                r_bad   <= '0;
              end
            end else begin
              r_state <= UNLOCKED;
              r_cnt   <= '0;
              r_lfsr  <= SEED;
            end
          end
          LOCKED: begin
            if (w_hdr_ok) begin
              r_bad <= '0;
            end else if (r_bad + 8'd1 == c_UNLOCK_CNT) begin
              r_state <= UNLOCKED;
              r_cnt   <= '0;
              r_bad   <= '0;
              r_lfsr  <= SEED;
            end else begin
              r_bad <= r_bad + 8'd1;
            end
          end
          default: r_state <= UNLOCKED;
        endcase
      end
    end
  end

  assign data_out = r_data;
  assign hdr_out  = r_hdr;
  assign locked   = (r_state == LOCKED);
  assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: rtl/lanes_rx_descrambler_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lanes_rx_descrambler_sync : two-lane word tick, descramble/lock, outputs   |
// | Revision                  : 1.0                                            |
// +----------------------------------------------------------------------------+
module lanes_rx_descrambler_sync
  import lanes_rx_pkg::*;
#(
  parameter logic [22:0] SEED_L0    = 23'h1DBFBC,
  parameter logic [22:0] SEED_L1    = 23'h0607BB,
  parameter int          LOCK_CNT   = 8,
  parameter int          UNLOCK_CNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   gen_speed,
  input  logic         enable_dec,
  input  logic         descr_rst,
  input  logic [131:0] lane_0_rx_in,
  input  logic [131:0] lane_1_rx_in,
  output logic [127:0] lane_0_data_out,
  output logic [127:0] lane_1_data_out,
  output logic [3:0]   lane_0_hdr_out,
  output logic [3:0]   lane_1_hdr_out,
  output logic         data_valid,
  output logic [1:0]   block_lock,
  output logic [1:0]   sync_err
);

  logic [2:0]   r_tick_sr;
  logic         r_cap_d;
  logic         w_capture;
  logic [131:0] w_rx   [2];
  logic [127:0] w_data [2];
  logic [3:0]   w_hdr  [2];
  logic [1:0]   w_locked;
  logic [1:0]   w_sync_err;

  // Third pipeline stage lines the capture up with the deserializer's word update
  assign w_capture = r_tick_sr[2];
  assign w_rx[0]   = lane_0_rx_in;
  assign w_rx[1]   = lane_1_rx_in;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    lane_descrambler #(
      .SEED       ((g == 0) ? SEED_L0 : SEED_L1),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable_dec),
      .capture   (w_capture),
      .gen_speed (gen_speed),
      .rx_in     (w_rx[g]),
      .data_out  (w_data[g]),
      .hdr_out   (w_hdr[g]),
      .locked    (w_locked[g]),
      .sync_err  (w_sync_err[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_sr       <= '0;
      r_cap_d         <= 1'b0;
      data_valid      <= 1'b0;
      lane_0_data_out <= '0;
      lane_1_data_out <= '0;
      lane_0_hdr_out  <= '0;
      lane_1_hdr_out  <= '0;
    end else if (!enable_dec) begin
      r_tick_sr       <= '0;
      r_cap_d         <= 1'b0;
      data_valid      <= 1'b0;
      lane_0_data_out <= '0;
      lane_1_data_out <= '0;
      lane_0_hdr_out  <= '0;
      lane_1_hdr_out  <= '0;
    end else begin
      r_tick_sr  <= {r_tick_sr[1:0], descr_rst};
      r_cap_d    <= w_capture;
      data_valid <= r_cap_d & (&w_locked);
      if (r_cap_d) begin
        lane_0_data_out <= w_data[0];
        lane_1_data_out <= w_data[1];
        lane_0_hdr_out  <= w_hdr[0];
        lane_1_hdr_out  <= w_hdr[1];
      end
    end
  end

  assign block_lock = w_locked;
  assign sync_err   = w_sync_err;

endmodule
`default_nettype wire
